// File: rtl/rvc_asap_5pl_d_mem_arb.sv
// Data-memory arbiter: core has fixed priority, E wins after STARVE_LIMIT denied cycles.
// Load data returns one cycle after the grant and is steered to the requester that issued it.
module rvc_asap_5pl_d_mem_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_wren,
    input  logic [31:0] c_address,
    input  logic [31:0] c_data,
    input  logic [3:0]  c_byteena,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        e_req,
    input  logic        e_wren,
    input  logic [31:0] e_address,
    input  logic [31:0] e_data,
    input  logic [3:0]  e_byteena,
    output logic        e_gnt,
    output logic        e_rvalid,
    output logic [31:0] e_rdata,
    output logic        m_wren,
    output logic        m_rden,
    output logic [31:0] m_address,
    output logic [31:0] m_data,
    output logic [3:0]  m_byteena,
    input  logic [31:0] m_q
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_wait_cnt;
    logic       r_rd_pend;
    logic       r_rd_owner;
    logic       w_starve;

    assign w_starve = (r_wait_cnt == LIMIT);

    // Grants are gated by rst_n so nothing reaches the memory while reset is held.
    assign e_gnt = rst_n && e_req && (!c_req || w_starve);
    assign c_gnt = rst_n && c_req && !e_gnt;

    always_comb begin
        m_wren    = 1'b0;
        m_rden    = 1'b0;
        m_address = '0;
        m_data    = '0;
        m_byteena = '0;
        if (e_gnt) begin
            m_wren    = e_wren;
            m_rden    = !e_wren;
            m_address = e_address;
            m_data    = e_data;
            m_byteena = e_byteena;
        end else if (c_gnt) begin
            m_wren    = c_wren;
            m_rden    = !c_wren;
            m_address = c_address;
            m_data    = c_data;
            m_byteena = c_byteena;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (e_req && !e_gnt) begin
                if (r_wait_cnt != LIMIT) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            r_rd_pend <= m_rden;
            if (m_rden) begin
                r_rd_owner <= e_gnt;
            end
        end
    end

    assign c_rvalid = r_rd_pend && !r_rd_owner;
    assign e_rvalid = r_rd_pend && r_rd_owner;
    assign c_rdata  = c_rvalid ? m_q : 32'd0;
    assign e_rdata  = e_rvalid ? m_q : 32'd0;

endmodule

// File: tb/tb_rvc_asap_5pl_d_mem_arb.sv
// Bench for the data-memory arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_rvc_asap_5pl_d_mem_arb;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req = 1'b0, c_wren = 1'b0;
    logic [31:0] c_address = '0, c_data = '0;
    logic [3:0]  c_byteena = '0;
    logic        e_req = 1'b0, e_wren = 1'b0;
    logic [31:0] e_address = '0, e_data = '0;
    logic [3:0]  e_byteena = '0;
    logic        c_gnt, c_rvalid, e_gnt, e_rvalid;
    logic [31:0] c_rdata, e_rdata;
    logic        m_wren, m_rden;
    logic [31:0] m_address, m_data, m_q;
    logic [3:0]  m_byteena;

    int vectors = 0;
    int miscompares = 0;

    rvc_asap_5pl_d_mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .rst_n(rst_n),
        .c_req(c_req), .c_wren(c_wren), .c_address(c_address), .c_data(c_data),
        .c_byteena(c_byteena), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .e_req(e_req), .e_wren(e_wren), .e_address(e_address), .e_data(e_data),
        .e_byteena(e_byteena), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .m_wren(m_wren), .m_rden(m_rden), .m_address(m_address), .m_data(m_data),
        .m_byteena(m_byteena), .m_q(m_q)
    );

    always #5 clock = ~clock;

    // Memory seen by the DUT and an independent reference copy used by the model.
    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        logic [31:0] rd;
        rd = mem.exists(m_address[31:2]) ? mem[m_address[31:2]] : 32'd0;
        if (m_rden) m_q <= rd;
        if (m_wren) mem[m_address[31:2]] = merge(rd, m_data, m_byteena);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Reference model: E wins when C is idle or E has been denied LIMIT cycles in a row.
    int          denied = 0;
    logic        pend_v = 1'b0, pend_e = 1'b0;
    logic [31:0] pend_d = '0;

    always @(negedge clock) begin
        logic        eg, cg, wr, ld;
        logic [31:0] a, d, old;
        logic [3:0]  be;
        if (!rst_n) begin
            denied = 0;
            pend_v = 1'b0;
            eg = 1'b0;
            cg = 1'b0;
        end else begin
            eg = e_req && (!c_req || denied >= LIMIT);
            cg = c_req && !eg;
        end
        wr = eg ? e_wren : c_wren;
        a  = eg ? e_address : c_address;
        d  = eg ? e_data : c_data;
        be = eg ? e_byteena : c_byteena;
        chk("e_gnt", 32'(e_gnt), 32'(eg));
        chk("c_gnt", 32'(c_gnt), 32'(cg));
        chk("m_wren", 32'(m_wren), 32'((eg || cg) && wr));
        chk("m_rden", 32'(m_rden), 32'((eg || cg) && !wr));
        chk("m_address", m_address, (eg || cg) ? a : 32'd0);
        chk("m_data", m_data, (eg || cg) ? d : 32'd0);
        chk("m_byteena", 32'(m_byteena), (eg || cg) ? 32'(be) : 32'd0);
        chk("c_rvalid", 32'(c_rvalid), 32'(pend_v && !pend_e));
        chk("e_rvalid", 32'(e_rvalid), 32'(pend_v && pend_e));
        chk("c_rdata", c_rdata, (pend_v && !pend_e) ? pend_d : 32'd0);
        chk("e_rdata", e_rdata, (pend_v && pend_e) ? pend_d : 32'd0);
        chk("wait_cnt", 32'(dut.r_wait_cnt), 32'(denied));
        if (rst_n) begin
            ld  = (eg || cg) && !wr;
            old = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'd0;
            pend_v = ld;
            if (ld) begin
                pend_e = eg;
                pend_d = old;
            end
            if ((eg || cg) && wr) ref_mem[a[31:2]] = merge(old, d, be);
            if (e_req && !eg) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
            else denied = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        c_req = 1'b0; c_wren = 1'b0; c_address = '0; c_data = '0; c_byteena = '0;
        e_req = 1'b0; e_wren = 1'b0; e_address = '0; e_data = '0; e_byteena = '0;
    endtask

    task automatic set_c(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        c_req = 1'b1; c_wren = wr; c_address = a; c_data = d; c_byteena = be;
    endtask

    task automatic set_e(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        e_req = 1'b1; e_wren = wr; e_address = a; e_data = d; e_byteena = be;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a[31:2]]     = d;
        ref_mem[a[31:2]] = d;
    endtask

    initial begin
        preload(32'h1000, 32'hDEADBEEF);
        preload(32'h10, 32'h11111111);
        preload(32'h14, 32'h22222222);
        preload(32'h18, 32'h33333333);
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Idle traffic
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("idle_m_rden", 32'(m_rden), 32'd0);
            chk("idle_wait", 32'(dut.r_wait_cnt), 32'd0);
            tick();
        end

        // E-only load
        set_e(1'b0, 32'h1000, 32'h0, 4'hF);
        mid();
        chk("s1_e_gnt", 32'(e_gnt), 32'd1);
        chk("s1_m_address", m_address, 32'h1000);
        tick();
        idle();
        mid();
        chk("s1_e_rvalid", 32'(e_rvalid), 32'd1);
        chk("s1_e_rdata", e_rdata, 32'hDEADBEEF);
        chk("s1_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();

        // Starvation: C wins four cycles, then E
        set_c(1'b0, 32'h10, 32'h0, 4'hF);
        set_e(1'b0, 32'h14, 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("s2_wait", 32'(dut.r_wait_cnt), 32'(k));
            chk("s2_c_gnt", 32'(c_gnt), (k < 4) ? 32'd1 : 32'd0);
            chk("s2_e_gnt", 32'(e_gnt), (k < 4) ? 32'd0 : 32'd1);
            tick();
        end
        e_req = 1'b0;
        mid();
        chk("s2_wait_clr", 32'(dut.r_wait_cnt), 32'd0);
        chk("s2_e_rdata", e_rdata, 32'h22222222);
        tick();
        idle();

        // Partial store then load
        set_c(1'b1, 32'h2000, 32'hA5A5A5A5, 4'h3);
        mid();
        chk("s3_m_wren", 32'(m_wren), 32'd1);
        tick();
        set_c(1'b0, 32'h2000, 32'h0, 4'hF);
        mid();
        chk("s3_m_rden", 32'(m_rden), 32'd1);
        tick();
        idle();
        mid();
        chk("s3_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("s3_c_rdata", c_rdata, 32'h0000A5A5);
        tick();

        // Alternating back-to-back loads
        set_c(1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        idle();
        set_e(1'b0, 32'h14, 32'h0, 4'hF);
        mid();
        chk("s4_c_rdata", c_rdata, 32'h11111111);
        tick();
        idle();
        set_c(1'b0, 32'h18, 32'h0, 4'hF);
        mid();
        chk("s4_e_rdata", e_rdata, 32'h22222222);
        chk("s4_c_rvalid0", 32'(c_rvalid), 32'd0);
        tick();
        idle();
        mid();
        chk("s4_c_rdata2", c_rdata, 32'h33333333);
        tick();

        // Reset on the cycle after an E load grant
        set_e(1'b0, 32'h1000, 32'h0, 4'hF);
        tick();
        rst_n = 1'b0;
        set_c(1'b0, 32'h10, 32'h0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("s5_e_rvalid", 32'(e_rvalid), 32'd0);
            chk("s5_e_rdata", e_rdata, 32'd0);
            chk("s5_gnts", 32'({c_gnt, e_gnt}), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        c_req = 1'b0;
        mid();
        chk("s5_e_gnt", 32'(e_gnt), 32'd1);
        chk("s5_wait", 32'(dut.r_wait_cnt), 32'd0);
        tick();
        idle();

        // Randomized traffic; payload held until granted
        for (int i = 0; i < 600; i++) begin
            if (!c_req || c_gnt) begin
                if ($urandom_range(0, 3) != 0)
                    set_c(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15)) * 4,
                          $urandom, 4'($urandom_range(1, 15)));
                else c_req = 1'b0;
            end
            if (!e_req || e_gnt) begin
                if ($urandom_range(0, 2) == 0)
                    set_e(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15)) * 4,
                          $urandom, 4'($urandom_range(1, 15)));
                else e_req = 1'b0;
            end
            if (i == 300) rst_n = 1'b0;
            if (i == 302) rst_n = 1'b1;
            mid();
            tick();
        end
        idle();
        tick();
        mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
